// File: rtl/qpsk_llr_packer.sv
// qpsk_llr_packer
// Turns strobed pairs of QPSK soft values into noise-scaled, saturated 8-bit LLRs.
// Each strobe yields one 32-bit word, tagged with an end-of-user flag.
// Words pass through a small first-word-fall-through FIFO with a ready/valid output.
// Upstream is throttled through a registered hold flag.
module qpsk_llr_packer #(
    parameter int P_GAIN       = 3,
    parameter int P_FIFO_DEPTH = 4
) (
    input  logic        i_core_clk,
    input  logic        i_rx_rst,
    input  logic        i_user_start,
    input  logic [15:0] i_cur_user_re_amounts,
    input  logic        i_data_strobe,
    input  logic [15:0] i_re0_data_i,
    input  logic [15:0] i_re0_data_q,
    input  logic [15:0] i_re1_data_i,
    input  logic [15:0] i_re1_data_q,
    input  logic [15:0] i_noise_data,
    output logic        o_hold,
    output logic        o_llr_valid,
    input  logic        i_llr_ready,
    output logic [31:0] o_llr_data,
    output logic        o_llr_last,
    output logic        o_overflow
);

    localparam int LP_AW = $clog2(P_FIFO_DEPTH);
    localparam int LP_CW = LP_AW + 1;
    localparam int LP_OW = LP_CW + 1;
    localparam int LP_XW = 24;

    // floor(log2(v)); zero maps to zero
    function automatic logic [3:0] f_floor_log2(input logic [15:0] v);
        logic [3:0] r;
        r = '0;
        for (int k = 0; k < 16; k++) begin
            if (v[k]) begin
                r = 4'(k);
            end
        end
        return r;
    endfunction

    // ---------------------------------------------------------------
    // Stage 1: capture, noise exponent, RE counting
    // ---------------------------------------------------------------
    logic              r_s1_valid;
    logic              r_s1_last;
    logic [3:0]        r_s1_shift;
    logic [3:0][15:0]  r_s1_lane;
    logic [15:0]       r_cnt;
    logic [15:0]       r_amt;

    logic [3:0][15:0]  w_in_lane;
    logic [15:0]       w_cnt_base;
    logic [15:0]       w_amt_cur;
    logic [16:0]       w_cnt_plus2;
    logic              w_last;
    logic              w_zero_re1;

    assign w_in_lane   = {i_re1_data_q, i_re1_data_i, i_re0_data_q, i_re0_data_i};
    // a user start in the same cycle makes this strobe the first pair of the new user
    assign w_cnt_base  = i_user_start ? 16'd0 : r_cnt;
    assign w_amt_cur   = i_user_start ? i_cur_user_re_amounts : r_amt;
    assign w_cnt_plus2 = {1'b0, w_cnt_base} + 17'd2;
    assign w_last      = (w_cnt_plus2 >= {1'b0, w_amt_cur});
    assign w_zero_re1  = w_last && w_amt_cur[0];

    // Register the RE pair, the noise exponent and the user bookkeeping
    always_ff @(posedge i_core_clk or posedge i_rx_rst) begin
        if (i_rx_rst) begin
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_shift <= '0;
            r_s1_lane  <= '0;
            r_cnt      <= '0;
            r_amt      <= '0;
        end else begin
            r_s1_valid <= i_data_strobe;
            if (i_user_start) begin
                r_cnt <= '0;
                r_amt <= i_cur_user_re_amounts;
            end
            if (i_data_strobe) begin
                r_cnt        <= w_last ? 16'd0 : w_cnt_plus2[15:0];
                r_s1_last    <= w_last;
                r_s1_shift   <= f_floor_log2(i_noise_data);
                r_s1_lane[0] <= w_in_lane[0];
                r_s1_lane[1] <= w_in_lane[1];
                // odd user length: the second RE of the final pair does not exist
                r_s1_lane[2] <= w_zero_re1 ? 16'd0 : w_in_lane[2];
                r_s1_lane[3] <= w_zero_re1 ? 16'd0 : w_in_lane[3];
            end
        end
    end

    // ---------------------------------------------------------------
    // Stage 2: gain, noise scaling and symmetric saturation per lane
    // ---------------------------------------------------------------
    logic [3:0][7:0] w_s2_byte;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic signed [LP_XW-1:0] w_ext;
            logic signed [LP_XW-1:0] w_scaled;
            assign w_ext    = {{(LP_XW-16){r_s1_lane[gi][15]}}, r_s1_lane[gi]};
            // arithmetic right shift keeps negative values rounding toward -inf
            assign w_scaled = (w_ext <<< P_GAIN) >>> r_s1_shift;
            // clamp to +/-127 so the code -128 never appears
            assign w_s2_byte[gi] = (w_scaled > 24'sd127)  ? 8'h7F :
                                   (w_scaled < -24'sd127) ? 8'h81 :
                                   w_scaled[7:0];
        end
    endgenerate

    logic        r_s2_valid;
    logic        r_s2_last;
    logic [31:0] r_s2_data;

    // Register the packed LLR word and its end-of-user flag
    always_ff @(posedge i_core_clk or posedge i_rx_rst) begin
        if (i_rx_rst) begin
            r_s2_valid <= 1'b0;
            r_s2_last  <= 1'b0;
            r_s2_data  <= '0;
        end else begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_data <= w_s2_byte;
                r_s2_last <= r_s1_last;
            end
        end
    end

    // ---------------------------------------------------------------
    // Stage 3: first-word-fall-through FIFO
    // ---------------------------------------------------------------
    logic [32:0]      r_mem [P_FIFO_DEPTH];
    logic [LP_AW-1:0] r_wr_ptr;
    logic [LP_AW-1:0] r_rd_ptr;
    logic [LP_CW-1:0] r_count;
    logic             r_overflow;
    logic             r_hold;

    logic             w_rd;
    logic             w_full;
    logic             w_wr;
    logic             w_drop;
    logic [32:0]      w_head;
    logic [LP_OW-1:0] w_occ;

    assign o_llr_valid = (r_count != '0);
    assign w_rd        = o_llr_valid && i_llr_ready;
    assign w_full      = (r_count == LP_CW'(P_FIFO_DEPTH));
    // a same-cycle read frees the slot, so a full FIFO still accepts the word
    assign w_wr        = r_s2_valid && (!w_full || w_rd);
    assign w_drop      = r_s2_valid && w_full && !w_rd;
    assign w_head      = r_mem[r_rd_ptr];

    // Storage array; contents are meaningless while the count says empty
    always_ff @(posedge i_core_clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= {r_s2_last, r_s2_data};
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge i_core_clk or posedge i_rx_rst) begin
        if (i_rx_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + LP_CW'(w_wr) - LP_CW'(w_rd);
        end
    end

    // Sticky drop flag, cleared when a new user begins
    always_ff @(posedge i_core_clk or posedge i_rx_rst) begin
        if (i_rx_rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (i_user_start) begin
            r_overflow <= 1'b0;
        end
    end

    // Words held or in flight, after the word leaving this cycle
    assign w_occ = {1'b0, r_count} - LP_OW'(w_rd) + LP_OW'(r_s1_valid) + LP_OW'(r_s2_valid);

    // Ask upstream to pause once only one slot of headroom remains
    always_ff @(posedge i_core_clk or posedge i_rx_rst) begin
        if (i_rx_rst) begin
            r_hold <= 1'b0;
        end else begin
            r_hold <= (w_occ >= LP_OW'(P_FIFO_DEPTH - 1));
        end
    end

    assign o_hold     = r_hold;
    assign o_overflow = r_overflow;
    assign o_llr_data = o_llr_valid ? w_head[31:0] : 32'd0;
    assign o_llr_last = o_llr_valid ? w_head[32] : 1'b0;

endmodule
